// File: rtl/uart_bfm_xcvr.sv
// 8N1 UART transceiver acting as the bench-side peer of the chip UART.
// Independent TX (level start/busy handshake) and RX (strobed bytes) paths.
module uart_bfm_xcvr #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t        r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_tx_armed;
    logic             r_ser_tx;
    logic             r_tx_busy;
    logic             r_tx_clear_req;

    // NOTE: all state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_tx_state     <= TX_IDLE;
            r_tx_cnt       <= '0;
            r_tx_bit       <= '0;
            r_tx_shift     <= '0;
            r_tx_armed     <= 1'b1;
            r_ser_tx       <= 1'b1;
            r_tx_busy      <= 1'b0;
            r_tx_clear_req <= 1'b0;
        end else begin
            r_tx_clear_req <= 1'b0;
            // Re-arm only once the requester has let go of tx_start.
            if (!tx_start) begin
                r_tx_armed <= 1'b1;
            end

            case (r_tx_state)
                TX_IDLE: begin
                    if (tx_start && r_tx_armed) begin
                        r_tx_armed <= 1'b0;
                        r_tx_shift <= tx_data;
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_ser_tx   <= 1'b0;
                        r_tx_busy  <= 1'b1;
                        r_tx_state <= TX_START;
                    end
                end

                TX_START: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt   <= '0;
                        r_ser_tx   <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end

                TX_DATA: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_ser_tx   <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_ser_tx   <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end

                TX_STOP: begin
                    if (r_tx_cnt == BIT_LAST) begin
                        r_tx_cnt       <= '0;
                        r_tx_busy      <= 1'b0;
                        r_tx_clear_req <= 1'b1;
                        r_tx_state     <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end

                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign ser_tx       = r_ser_tx;
    assign tx_busy      = r_tx_busy;
    assign tx_clear_req = r_tx_clear_req;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic w_rx_line;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= ser_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_rx_line = r_rx_sync;

    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_frame_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_state     <= RX_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;

            case (r_rx_state)
                RX_IDLE: begin
                    if (!w_rx_line) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end

                RX_START: begin
                    // A line that is high again at mid-start-bit was a glitch.
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt <= '0;
                        if (w_rx_line) begin
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_bit   <= '0;
                            r_rx_state <= RX_DATA;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end

                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end

                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt <= '0;
                        if (w_rx_line) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_rx_frame_err <= 1'b1;
                            r_rx_state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end

                RX_WAIT_HIGH: begin
                    if (w_rx_line) begin
                        r_rx_state <= RX_IDLE;
                    end
                end

                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_frame_err;

endmodule

// File: tb/tb_uart_bfm_xcvr.sv
// Bench for uart_bfm_xcvr: time-arithmetic TX model, RX byte scoreboard,
// and directed scenarios with hand-computed literal expectations.
module tb_uart_bfm_xcvr;

    localparam int CPB = 8;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic       drv_rx   = 1'b1;
    logic       loop_en  = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       ser_rx;
    logic       ser_tx;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    assign ser_rx = loop_en ? ser_tx : drv_rx;

    always #5 clock = ~clock;

    uart_bfm_xcvr #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .ser_rx       (ser_rx),
        .ser_tx       (ser_tx),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_clear_req (tx_clear_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t rx_q[$];
    int      n_valid = 0;
    int      n_err   = 0;

    // Model: a frame accepted at edge a drives bit floor((e-a)/CPB) of
    // {1, data, 0} after edge e, for 10*CPB edges, then one clear pulse.
    initial begin
        logic       m_armed;
        logic       m_active;
        int         m_cyc;
        int         m_acc;
        int         d;
        logic [9:0] m_frame;
        logic [7:0] m_rx_last;
        logic       s_rst, s_start;
        logic [7:0] s_data;
        logic       e_ser, e_busy, e_clr;
        rx_exp_t    front;
        m_armed   = 1'b1;
        m_active  = 1'b0;
        m_cyc     = 0;
        m_acc     = 0;
        m_frame   = '0;
        m_rx_last = 8'h00;
        forever begin
            @(posedge clock);
            s_rst   = reset;
            s_start = tx_start;
            s_data  = tx_data;
            m_cyc++;
            if (s_rst) begin
                m_armed   = 1'b1;
                m_active  = 1'b0;
                e_ser     = 1'b1;
                e_busy    = 1'b0;
                e_clr     = 1'b0;
                m_rx_last = 8'h00;
                rx_q.delete();
            end else begin
                if (!m_active && s_start && m_armed) begin
                    m_active = 1'b1;
                    m_armed  = 1'b0;
                    m_acc    = m_cyc;
                    m_frame  = {1'b1, s_data, 1'b0};
                    e_ser    = 1'b0;
                    e_busy   = 1'b1;
                    e_clr    = 1'b0;
                end else if (m_active) begin
                    d = m_cyc - m_acc;
                    if (d >= 10 * CPB) begin
                        m_active = 1'b0;
                        e_ser    = 1'b1;
                        e_busy   = 1'b0;
                        e_clr    = 1'b1;
                    end else begin
                        e_ser  = m_frame[d / CPB];
                        e_busy = 1'b1;
                        e_clr  = 1'b0;
                    end
                end else begin
                    e_ser  = 1'b1;
                    e_busy = 1'b0;
                    e_clr  = 1'b0;
                end
                if (!s_start) m_armed = 1'b1;
            end
            #1;
            check("ser_tx", ser_tx, e_ser);
            check("tx_busy", tx_busy, e_busy);
            check("tx_clear_req", tx_clear_req, e_clr);
            check("rx_strobe_exclusive", rx_valid & rx_frame_err, 0);
            if (rx_valid || rx_frame_err) begin
                check("rx_strobe_expected", rx_q.size() > 0, 1);
                if (rx_q.size() > 0) begin
                    front = rx_q.pop_front();
                    check("rx_strobe_kind", rx_frame_err, front.err);
                    if (rx_valid) begin
                        check("rx_byte", rx_data, front.data);
                        m_rx_last = front.data;
                    end
                end
                if (rx_valid) n_valid++;
                if (rx_frame_err) n_err++;
            end
            check("rx_data_hold", rx_data, m_rx_last);
        end
    end

    // Frame monitor: busy/clear counts and mid-bit samples of ser_tx.
    int   busy_cycles = 0;
    int   clr_pulses  = 0;
    int   frames      = 0;
    int   bi          = 0;
    logic prev_busy   = 1'b0;
    logic cap [10];

    initial begin
        forever begin
            @(negedge clock);
            if (tx_clear_req === 1'b1) clr_pulses++;
            if (tx_busy === 1'b1) begin
                if (!prev_busy) begin
                    frames++;
                    bi = 0;
                end
                busy_cycles++;
                if ((bi % CPB) == CPB / 2 && (bi / CPB) < 10) cap[bi / CPB] = ser_tx;
                bi++;
            end
            prev_busy = (tx_busy === 1'b1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_busy(input logic lvl, input int budget, input string name);
        int i;
        i = 0;
        while (tx_busy !== lvl && i < budget) begin
            @(negedge clock);
            i++;
        end
        check(name, tx_busy, lvl);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx_exp_t e;
        e.err  = ~stop_bit;
        e.data = b;
        rx_q.push_back(e);
        drv_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            drv_rx = b[i];
            tick(CPB);
        end
        drv_rx = stop_bit;
        tick(CPB);
        drv_rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic send_loop(input logic [7:0] b);
        rx_exp_t e;
        e.err  = 1'b0;
        e.data = b;
        rx_q.push_back(e);
        tx_data  = b;
        tx_start = 1'b1;
    endtask

    logic exp_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int bc0, cp0, fr0, nv0, ne0;
        tick(3);
        check("reset_ser_tx", ser_tx, 1);
        check("reset_tx_busy", tx_busy, 0);
        check("reset_tx_clear_req", tx_clear_req, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        reset = 1'b0;
        tick(4);

        // 0x3D in loopback, tx_start held until busy falls.
        loop_en = 1'b1;
        bc0 = busy_cycles;
        cp0 = clr_pulses;
        send_loop(8'h3D);
        check("tx_busy_before_edge", tx_busy, 0);
        tick(1);
        check("tx_busy_latency", tx_busy, 1);
        wait_busy(1'b0, 12 * CPB, "tx_busy_fall_3d");
        tx_start = 1'b0;
        tick(2);
        check("busy_len_3d", busy_cycles - bc0, 80);
        check("clear_pulses_3d", clr_pulses - cp0, 1);
        for (int i = 0; i < 10; i++) check($sformatf("frame_3d_bit%0d", i), cap[i], exp_bits[i]);

        // 0x0F with tx_start held for 300 cycles: one frame only.
        fr0 = frames;
        send_loop(8'h0F);
        tick(300);
        check("held_start_frames", frames - fr0, 1);
        tx_start = 1'b0;
        tick(20);
        check("loop_valid_count", n_valid, 2);
        check("loop_err_count", n_err, 0);
        check("loop_last_byte", rx_data, 8'h0F);

        // Short low glitch on the line.
        loop_en = 1'b0;
        drv_rx  = 1'b1;
        tick(4);
        nv0 = n_valid;
        ne0 = n_err;
        drv_rx = 1'b0;
        tick(2);
        drv_rx = 1'b1;
        tick(40);
        check("glitch_no_valid", n_valid - nv0, 0);
        check("glitch_no_err", n_err - ne0, 0);

        // 0xA5 with a low stop bit, then a good 0x55.
        drive_frame(8'hA5, 1'b0);
        check("frame_err_count", n_err - ne0, 1);
        check("frame_err_keeps_data", rx_data, 8'h0F);
        drive_frame(8'h55, 1'b1);
        check("after_err_valid_count", n_valid - nv0, 1);
        check("after_err_byte", rx_data, 8'h55);

        // Reset while TX is in its data bits, with tx_start still high.
        tx_data  = 8'hC3;
        tx_start = 1'b1;
        tick(30);
        check("pre_reset_busy", tx_busy, 1);
        reset = 1'b1;
        tick(1);
        check("mid_reset_ser_tx", ser_tx, 1);
        check("mid_reset_busy", tx_busy, 0);
        reset = 1'b0;
        tick(1);
        check("post_reset_restart", tx_busy, 1);
        wait_busy(1'b0, 12 * CPB, "tx_busy_fall_c3");
        tx_start = 1'b0;
        tick(10);

        check("rx_queue_drained", rx_q.size(), 0);
        check("total_valid", n_valid, 3);
        check("total_err", n_err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_bfm_xcvr.md
Name: uart_bfm_xcvr

Overview:
- Synthesizable 8N1 UART transceiver used as the bench-side peer of the chip UART (chip mprj_io[6] TX, mprj_io[5] RX).
- Receives bytes the firmware transmits and reports each on a one-cycle strobe.
- Transmits single bytes on request using a level-held start/busy handshake, so the bench can inject stimulus bytes (e.g. 61, 15) into the chip.

Parameters:
- CLKS_PER_BIT, default 104: clock cycles per UART bit. Must be ≥ 4. Bit centre = CLKS_PER_BIT/2 (integer division).

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- ser_rx  input  1  serial input from chip TX; asynchronous, idles high
- ser_tx  output  1  serial output to chip RX; idles high
- tx_start  input  1  transmit request, level; held high by the requester until tx_busy falls
- tx_data  input  8  byte to send; sampled on acceptance only
- tx_busy  output  1  high while a frame is in flight
- tx_clear_req  output  1  one-cycle pulse at frame end, asking the requester to drop tx_start
- rx_data  output  8  last correctly received byte
- rx_valid  output  1  one-cycle strobe: rx_data updated
- rx_frame_err  output  1  one-cycle strobe: stop bit sampled low

Behaviour:
- Reset values: ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0, rx_valid=0, rx_frame_err=0. Both FSMs return to IDLE, TX armed flag=1. Reset mid-frame aborts the frame and ser_tx returns to 1 on the next edge.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLKS_PER_BIT cycles. A frame is 10*CLKS_PER_BIT cycles.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: when tx_start=1 and armed=1 (acceptance), latch tx_data, clear armed, go to START.
  - Timing: tx_busy=1 and ser_tx=0 from the cycle after acceptance.
  - DATA shifts out bits 0..7. STOP drives 1.
  - After the last stop-bit cycle, return to IDLE: tx_busy=0 and tx_clear_req=1 for one cycle.
  - armed is set again in any cycle where tx_start=0. A held tx_start therefore yields exactly one frame.
  - Back-to-back transfers require tx_start low for at least 1 cycle.
  - tx_data and tx_start changes during a frame are ignored.
- RX path: ser_rx passes through a 2-flop synchronizer (2-cycle latency); the FSM uses only the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: synchronized line low, go to START.
  - START: at cycle CLKS_PER_BIT/2 resample. If high, treat as a glitch and return to IDLE without strobes. If low, go to DATA.
  - DATA: sample 8 bits at successive bit centres (every CLKS_PER_BIT cycles) into a shift register, LSB first.
  - STOP: sample at stop-bit centre.
    - High: rx_data updated and rx_valid=1 for one cycle.
    - Low: rx_frame_err=1 for one cycle, rx_data unchanged.
  - Error case: go to WAIT_HIGH until the line is high, then IDLE.
  - Good stop bit: go directly to IDLE, so a new start may begin half a bit after the stop centre.
- rx_valid and rx_frame_err are never both high.
- TX and RX are fully independent. Loopback (ser_tx wired to ser_rx) must work.

Test Plan:
- Send 0x3D, CLKS_PER_BIT=8, tx_start held until tx_busy falls → ser_tx bit sequence 0,1,0,1,1,1,1,0,0,1, each 8 cycles. tx_busy high 80 cycles, asserted 1 cycle after tx_start. tx_clear_req single pulse as busy falls.
- Hold tx_start high for 300 cycles with tx_data=0x0F → exactly one frame; no second start bit until tx_start drops and rises again.
- Loopback, send 61 then 15 (tx_start dropped between) → rx_valid pulses twice with rx_data 0x3D then 0x0F. rx_frame_err never asserts.
- Drive ser_rx low for 2 cycles (glitch shorter than half a bit) → no rx_valid, no rx_frame_err, FSM back in IDLE.
- Drive frame 0xA5 with stop bit 0, then line high → rx_frame_err one pulse, rx_data keeps its previous value. The following good frame 0x55 yields rx_valid with 0x55.
- Assert reset mid-frame (TX in DATA) → next cycle ser_tx=1, tx_busy=0. With tx_start still high after reset release, a fresh frame starts.
